branch_ctrl: RTL

Branch sequencing controller for the 5-stage RISC-V core. Predicts conditional-branch (SB-type) direction in ID from a bimodal table of 2-bit saturating counters and redirects fetch on predicted-taken. Checks the prediction in EX against the branch comparator's `Branch` output. On mispredict it redirects fetch and flushes the wrong path, and it keeps branch and mispredict statistics.

---
 rtl/riscv_pkg.sv | 14 +
 rtl/branch_ctrl_if.sv | 22 ++
 rtl/branch_bht.sv | 25 ++
 rtl/branch_ctrl.sv | 52 +++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared encodings and helpers for the branch sequencing logic.
package riscv_pkg;
   typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} bht_cnt_t;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

   function automatic bht_cnt_t cnt_step(bht_cnt_t c, logic taken);
      return taken ? (c == ST ? ST : bht_cnt_t'(c + 2'd1)) : (c == SNT ? SNT : bht_cnt_t'(c - 2'd1));
   endfunction

   function automatic logic [31:0] sat_inc(logic [31:0] v, logic en);
      return (en && v != CNT_MAX) ? v + 32'd1 : v;
   endfunction
endpackage

// File: rtl/branch_ctrl_if.sv
// branch_ctrl_if: ID/EX branch inputs, fetch redirect and statistics outputs.
interface branch_ctrl_if #(parameter int XLEN = 32);
   logic            id_valid, id_is_branch, id_stall, id_pred_taken;
   logic [XLEN-1:0] id_pc, id_target;
   logic            ex_valid, ex_is_branch, ex_pred_taken, ex_taken;
   logic [XLEN-1:0] ex_pc, ex_target;
   logic            redirect, flush_ifid, flush_idex;
   logic [XLEN-1:0] redirect_pc;
   logic [31:0]     branch_cnt, miss_cnt;

   modport master (
      output id_valid, id_is_branch, id_stall, id_pc, id_target,
      output ex_valid, ex_is_branch, ex_pred_taken, ex_taken, ex_pc, ex_target,
      input  id_pred_taken, redirect, redirect_pc, flush_ifid, flush_idex, branch_cnt, miss_cnt
   );

   modport slave (
      input  id_valid, id_is_branch, id_stall, id_pc, id_target,
      input  ex_valid, ex_is_branch, ex_pred_taken, ex_taken, ex_pc, ex_target,
      output id_pred_taken, redirect, redirect_pc, flush_ifid, flush_idex, branch_cnt, miss_cnt
   );
endinterface

// File: rtl/branch_bht.sv
// branch_bht: bimodal table of 2-bit saturating counters, async read, sync update.
module branch_bht
   import riscv_pkg::*;
#(
   parameter int IDX_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IDX_W-1:0] rd_idx,
   output bht_cnt_t         rd_cnt,
   input  logic             upd_valid,
   input  logic [IDX_W-1:0] upd_idx,
   input  logic             upd_taken
);
   bht_cnt_t tbl [2**IDX_W];

   // No bypass: a same-index read during an update sees the old counter.
   assign rd_cnt = tbl[rd_idx];

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)
         for (int i = 0; i < 2**IDX_W; i++) tbl[i] <= WNT;
      else if (upd_valid)
         tbl[upd_idx] <= cnt_step(tbl[upd_idx], upd_taken);
endmodule

// File: rtl/branch_ctrl.sv
// branch_ctrl: ID-stage bimodal prediction, EX-stage resolution, redirect/flush
// priority and saturating branch/mispredict statistics.
module branch_ctrl
   import riscv_pkg::*;
#(
   parameter int BHT_IDX_W = 4,
   parameter int XLEN      = 32
) (
   input logic         clk,
   input logic         rst_n,
   branch_ctrl_if.slave bus
);
   logic        ex_resolve, ex_miss, id_hit, id_go;
   bht_cnt_t    id_cnt;
   logic [31:0] branch_cnt, miss_cnt;

   branch_bht #(.IDX_W(BHT_IDX_W)) u_bht (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_idx    (bus.id_pc[BHT_IDX_W+1:2]),
      .rd_cnt    (id_cnt),
      .upd_valid (ex_resolve),
      .upd_idx   (bus.ex_pc[BHT_IDX_W+1:2]),
      .upd_taken (bus.ex_taken)
   );

   // EX mispredict outranks an ID predicted-taken redirect.
   always_comb begin
      ex_resolve        = bus.ex_valid & bus.ex_is_branch;
      ex_miss           = ex_resolve & (bus.ex_taken != bus.ex_pred_taken);
      id_hit            = bus.id_valid & bus.id_is_branch & (id_cnt inside {WT, ST});
      id_go             = id_hit & ~bus.id_stall;
      bus.id_pred_taken = id_hit;
      bus.redirect      = ex_miss | id_go;
      bus.redirect_pc   = ex_miss ? (bus.ex_taken ? bus.ex_target : bus.ex_pc + XLEN'(4)) :
                          id_go   ? bus.id_target : '0;
      bus.flush_ifid    = ex_miss | id_go;
      bus.flush_idex    = ex_miss;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         branch_cnt <= '0;
         miss_cnt   <= '0;
      end else begin
         branch_cnt <= sat_inc(branch_cnt, ex_resolve);
         miss_cnt   <= sat_inc(miss_cnt, ex_miss);
      end

   assign bus.branch_cnt = branch_cnt;
   assign bus.miss_cnt   = miss_cnt;
endmodule
